// File: rtl/sub64_pipe_if.sv
// Operand/result bundle for sub64_pipe: the in_* side comes from the issue queue
// and the out_*/diff/flag_* side goes to writeback and the compare/branch unit.
interface sub64_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             flag_z;
    logic             flag_n;
    logic             flag_b;
    logic             flag_v;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, flag_z, flag_n, flag_b, flag_v
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, flag_z, flag_n, flag_b, flag_v
    );
endinterface

// File: rtl/sub64_pipe.sv
// Pipelined a - b (as a + ~b + 1) over a registered Kogge-Stone carry network,
// with per-rank valid bits, bubble-collapsing stall and Z/N/B/V status flags.
module sub64_pipe #(
    parameter int WIDTH = 64  // power of two, at least 8
) (
    input logic         clk,
    input logic         rst,
    sub64_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NRANK  = LEVELS + 3;  // S0 capture, S1 p/g, LEVELS prefix ranks, output
    localparam int LAST   = NRANK - 1;

    logic [NRANK-1:0] vld;
    logic [NRANK-1:0] ld;

    // Rank k may load whenever some rank at or after k holds a bubble, or S8 drains.
    always_comb begin
        logic [NRANK-1:0] below;
        below = '0;
        ld    = '0;
        for (int k = 0; k < NRANK; k++) begin
            ld[k]    = bus.out_ready || ((vld | below) != '1);
            below[k] = 1'b1;
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld[LAST];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld <= '0;
        else      vld <= (ld & {vld[NRANK-2:0], bus.in_valid}) | (~ld & vld);
    end

    function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g,
                                              input logic [WIDTH-1:0] p,
                                              input int d);
        logic [WIDTH-1:0] r;
        r = g;
        for (int i = d; i < WIDTH; i++) r[i] = g[i] | (p[i] & g[i-d]);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p, input int d);
        logic [WIDTH-1:0] r;
        r = p;
        for (int i = d; i < WIDTH; i++) r[i] = p[i] & p[i-d];
        return r;
    endfunction

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic [WIDTH-1:0] g_q  [LEVELS+1];
    logic [WIDTH-1:0] p_q  [LEVELS];
    logic [WIDTH-1:0] p0_q [LEVELS+1];
    logic             am_q [LEVELS+1];
    logic             bm_q [LEVELS+1];

    // NOTE: datapath ranks have no reset; the valid bits alone say whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (ld[0]) begin
            a_q  <= bus.a;
            nb_q <= ~bus.b;
        end
        if (ld[1]) begin
            p_q[0]  <= a_q ^ nb_q;
            p0_q[0] <= a_q ^ nb_q;
            // Carry-in of 1 folded into bit 0: g0 = a0&~b0 | (a0^~b0)&1.
            g_q[0]  <= {a_q[WIDTH-1:1] & nb_q[WIDTH-1:1], a_q[0] | nb_q[0]};
            am_q[0] <= a_q[WIDTH-1];
            bm_q[0] <= ~nb_q[WIDTH-1];
        end
        for (int l = 0; l < LEVELS; l++) begin
            if (ld[l+2]) begin
                g_q[l+1]  <= ks_g(g_q[l], p_q[l], 1 << l);
                p0_q[l+1] <= p0_q[l];
                am_q[l+1] <= am_q[l];
                bm_q[l+1] <= bm_q[l];
            end
        end
        for (int l = 0; l < LEVELS - 1; l++) begin
            if (ld[l+2]) p_q[l+1] <= ks_p(p_q[l], 1 << l);
        end
    end

    // After the last prefix level g_q[LEVELS][i] is the carry out of bit i.
    logic [WIDTH-1:0] diff_nx;
    logic             cout;

    assign diff_nx = p0_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], 1'b1};
    assign cout    = g_q[LEVELS][WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.diff   <= '0;
            bus.flag_z <= 1'b0;
            bus.flag_n <= 1'b0;
            bus.flag_b <= 1'b0;
            bus.flag_v <= 1'b0;
        end else if (ld[LAST] && vld[LAST-1]) begin
            bus.diff   <= diff_nx;
            bus.flag_z <= ~|diff_nx;
            bus.flag_n <= diff_nx[WIDTH-1];
            bus.flag_b <= ~cout;
            bus.flag_v <= (am_q[LEVELS] != bm_q[LEVELS]) && (diff_nx[WIDTH-1] != am_q[LEVELS]);
        end
    end
endmodule
